// File: rtl/ercm8_if.sv
// ercm8_if: operand/result bundle for the ercm8 approximate multiplier.
// The master drives the operands and mask, and the slave (ercm8) returns the product.
interface ercm8_if;
    logic [7:0]  dat_in_a;
    logic [7:0]  dat_in_b;
    logic [6:0]  mask;
    logic [15:0] dat_o;

    modport master (output dat_in_a, output dat_in_b, output mask, input dat_o);
    modport slave  (input dat_in_a, input dat_in_b, input mask, output dat_o);
endinterface

// File: rtl/ercm8.sv
// ercm8: registered 8x8 unsigned approximate multiplier.
// Each of product columns 0..6 can be switched from exact popcount summation
// to a carry-free OR reduction through mask[c]. mask = 0 is an exact multiplier.
// Optional build macro ERCM8_IN_REG_EN adds input registers. This makes the
// latency 2 cycles instead of 1. Throughput and arithmetic do not change.
module ercm8 (
    input  logic    clk,
    input  logic    rst,
    ercm8_if.slave  bus
);
    localparam int NUM_COLS = 15;
    localparam int APX_COLS = 7;

    logic [7:0] a, b;
    logic [6:0] m;

`ifdef ERCM8_IN_REG_EN
    logic [7:0] a_q, b_q;
    logic [6:0] m_q;

    // Capture the operands and mask. All of them clear on reset, so that nothing in flight survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= bus.dat_in_a;
            b_q <= bus.dat_in_b;
            m_q <= bus.mask;
        end
    end

    assign a = a_q;
    assign b = b_q;
    assign m = m_q;
`else
    assign a = bus.dat_in_a;
    assign b = bus.dat_in_b;
    assign m = bus.mask;
`endif

    // Per-column population count and OR of the partial products a[i] & b[j] with i + j = c.
    logic [NUM_COLS-1:0][3:0] col_cnt;
    logic [NUM_COLS-1:0]      col_or;

    // Build the column statistics from the 64 partial products.
    always_comb begin
        col_cnt = '0;
        col_or  = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col_cnt[i+j] = col_cnt[i+j] + {3'b000, a[i] & b[j]};
                col_or[i+j]  = col_or[i+j] | (a[i] & b[j]);
            end
        end
    end

    // Column weight before shifting. A masked column collapses to a single bit, so it never carries.
    logic [NUM_COLS-1:0][3:0] col_val;

    genvar c;
    generate
        for (c = 0; c < NUM_COLS; c++) begin : g_col
            if (c < APX_COLS) begin : g_apx
                assign col_val[c] = m[c] ? {3'b000, col_or[c]} : col_cnt[c];
            end else begin : g_exact
                assign col_val[c] = col_cnt[c];
            end
        end
    endgenerate

    // Weighted sum of all columns. The maximum is 255*255, so 16 bits never wrap.
    logic [15:0] prod;

    always_comb begin
        prod = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            prod = prod + ({12'h000, col_val[k]} << k);
        end
    end

    logic [15:0] dat_q;

    // Output register. Reset has priority over new data.
    always_ff @(posedge clk) begin
        if (rst) dat_q <= '0;
        else     dat_q <= prod;
    end

    assign bus.dat_o = dat_q;
endmodule

// File: tb/tb_ercm8.sv
// tb_ercm8: directed and random checks for the ercm8 approximate multiplier.
module tb_ercm8;
`ifdef ERCM8_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ercm8_if bus();

    ercm8 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: the exact product minus the excess of each masked column
    // (popcount - 1 when the column is non-empty).
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [6:0] m);
        int p;
        int cnt;
        p = int'(a) * int'(b);
        for (int col = 0; col < 7; col++) begin
            if (m[col]) begin
                cnt = 0;
                for (int i = 0; i <= col; i++)
                    if (i < 8 && (col - i) < 8) cnt += int'(a[i] & b[col-i]);
                if (cnt > 0) p -= (cnt - 1) << col;
            end
        end
        return p[15:0];
    endfunction

    // Drive one operand set at the falling edge and return the result LAT edges later.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [6:0] m,
                       output logic [15:0] r);
        @(negedge clk);
        bus.dat_in_a = a;
        bus.dat_in_b = b;
        bus.mask     = m;
        repeat (LAT) @(posedge clk);
        #1 r = bus.dat_o;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.dat_in_a = 8'd255;
        bus.dat_in_b = 8'd255;
        bus.mask     = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.dat_o !== 16'h0000) begin
            n_err++;
            $display("FAIL reset: dat_o=%h expected 0000", bus.dat_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0]  ta [6] = '{8'd255, 8'd255, 8'd3, 8'd3, 8'd0,   8'd3};
        logic [7:0]  tb [6] = '{8'd255, 8'd255, 8'd3, 8'd3, 8'd200, 8'd3};
        logic [6:0]  tm [6] = '{7'h00,  7'h7F,  7'h02, 7'h01, 7'h7F, 7'h00};
        logic [15:0] te [6] = '{16'd65025, 16'd64383, 16'd7, 16'd9, 16'd0, 16'd9};
        logic [15:0] r;
        for (int k = 0; k < 6; k++) begin
            run(ta[k], tb[k], tm[k], r);
            n_vec++;
            if (r !== te[k]) begin
                n_err++;
                $display("FAIL directed[%0d] a=%0d b=%0d m=%h: got %0d expected %0d",
                         k, ta[k], tb[k], tm[k], r, te[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pa [3] = '{8'd255, 8'd3, 8'd0};
        logic [7:0]  pb [3] = '{8'd255, 8'd3, 8'd200};
        logic [15:0] pe [3] = '{16'd65025, 16'd9, 16'd0};
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            @(negedge clk);
            bus.dat_in_a = (k < 3) ? pa[k] : 8'd0;
            bus.dat_in_b = (k < 3) ? pb[k] : 8'd0;
            bus.mask     = 7'h00;
            @(posedge clk);
            #1;
            if (k >= LAT - 1) begin
                n_vec++;
                if (bus.dat_o !== pe[k-(LAT-1)]) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: got %0d expected %0d",
                             k - (LAT - 1), bus.dat_o, pe[k-(LAT-1)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] r;
        @(negedge clk);
        bus.dat_in_a = 8'd255;
        bus.dat_in_b = 8'd255;
        bus.mask     = 7'h00;
        @(negedge clk);
        rst = 1'b1;
        bus.dat_in_a = 8'd3;
        bus.dat_in_b = 8'd3;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.dat_o !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset: got %0d expected 0", bus.dat_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.dat_in_a = 8'd0;
        bus.dat_in_b = 8'd0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.dat_o !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_drop: got %0d expected 0", bus.dat_o);
        end
        run(8'd3, 8'd3, 7'h02, r);
        n_vec++;
        if (r !== 16'd7) begin
            n_err++;
            $display("FAIL mid_reset_recover: got %0d expected 7", r);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [6:0]  m;
        logic [15:0] r, e;
        for (int k = 0; k < 10000; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            m = 7'($urandom);
            run(a, b, m, r);
            e = model(a, b, m);
            n_vec++;
            if (r !== e) begin
                n_err++;
                $display("FAIL random a=%0d b=%0d m=%h: got %0d expected %0d", a, b, m, r, e);
            end
            if (r > 16'(int'(a) * int'(b))) begin
                n_err++;
                $display("FAIL bound a=%0d b=%0d m=%h: got %0d above %0d", a, b, m, r,
                         int'(a) * int'(b));
            end
        end
    endtask

    task automatic test_exact();
        logic [7:0]  a, b;
        logic [15:0] r;
        for (int k = 0; k < 2000; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run(a, b, 7'h00, r);
            n_vec++;
            if (r !== 16'(int'(a) * int'(b))) begin
                n_err++;
                $display("FAIL exact a=%0d b=%0d: got %0d expected %0d", a, b, r,
                         int'(a) * int'(b));
            end
        end
    endtask

    initial begin
        bus.dat_in_a = '0;
        bus.dat_in_b = '0;
        bus.mask     = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        test_exact();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
